// File: rtl/truth_table_sweeper.sv
// Sweeps every input pattern into a DUT and checks dut_f against a golden table.
// Define SWEEP_GRAY_ORDER_EN to step the stimulus in Gray-code order.
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int DWELL = 50,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t state, state_nx;
  logic [N_IN-1:0] idx;
  logic [CW-1:0] cnt;
  logic launch;
  logic sample;
  logic mismatch;

  function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign mismatch = dut_f != EXPECTED[stim];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    sample   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == CMAX) begin
          sample = 1'b1;
          if (idx == LAST) state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index stops at the last pattern so stim holds it through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      stim      <= '0;
      err_count <= '0;
      first_err <= '0;
    end else if (launch) begin
      idx       <= '0;
      cnt       <= '0;
      stim      <= '0;
      err_count <= '0;
      first_err <= '0;
    end else if (state == DRIVE) begin
      if (sample) begin
        cnt <= '0;
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (err_count == '0) first_err <= stim;
        end
        if (idx != LAST) begin
          idx  <= idx + 1'b1;
          stim <= code(idx + 1'b1);
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = state == DRIVE;
  assign done = state == DONE;
  assign pass = done && (err_count == '0);

endmodule
